// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit: PC owner and req/ack instruction fetcher feeding decode.       |
// | Optional FETCH_MISALIGN_TRAP_EN: halt with fetch_fault on misaligned PC.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            Pcsrc,
    input  logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic            funct7,
    output logic            fetch_fault
);

    typedef enum logic [1:0] {
        S_FLUSH = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            imem_req_q;
    logic            instr_valid_q;
    logic [XLEN-1:0] next_pc_raw;
    logic [XLEN-1:0] next_pc_d;

    assign pc_plus4    = pc_q + XLEN'(4);
    assign next_pc_raw = Pcsrc ? (pc_q + imm_ext) : pc_plus4;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;
    logic w_misalign;
    assign next_pc_d   = next_pc_raw;
    assign w_misalign  = |next_pc_raw[1:0];
    assign fetch_fault = fault_q;
`else
    assign next_pc_d   = next_pc_raw & ~XLEN'(3);
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FLUSH;
            pc_q          <= RESET_PC;
            instr_q       <= C_NOP;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                // Any ack arriving here belongs to a fetch abandoned by reset.
                S_FLUSH: begin
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_q       <= imem_rdata;
                        instr_valid_q <= 1'b1;
                        imem_req_q    <= 1'b0;
                        state_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        pc_q          <= next_pc_d;
                        instr_q       <= C_NOP;
                        instr_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (w_misalign) begin
                            fault_q <= 1'b1;
                            state_q <= S_HALT;
                        end else begin
                            imem_req_q <= 1'b1;
                            state_q    <= S_FETCH;
                        end
`else
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
`endif
                    end
                end
                S_HALT: begin
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
                default: begin
                    imem_req_q <= 1'b0;
                    state_q    <= S_FLUSH;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign opcode      = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7      = instr_q[30];

endmodule
`default_nettype wire
